// File: rtl/seg7_scan_n_if.sv
// Data/handshake bundle between system logic and the scanned display driver.
// The master side loads digit data; the slave side drives the LED pins.
interface seg7_scan_n_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lzs;
  logic                    load;
  logic [7:0]              LED7S;
  logic [NUM_DIGITS-1:0]   dig;
  logic                    frame_start;
  logic                    pending;

  modport master (
    output value, dp, blank, lzs, load,
    input  LED7S, dig, frame_start, pending
  );

  modport slave (
    input  value, dp, blank, lzs, load,
    output LED7S, dig, frame_start, pending
  );
endinterface

// File: rtl/seg7_scan_n.sv
// Time-multiplexed common-anode 7-segment driver for N hex digits with
// blanking gap, leading-zero suppression and frame-aligned data updates.
module seg7_scan_n #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_n_if.slave bus
);

  localparam int CW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam int IW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;

  logic [VW-1:0]         act_val;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_blank;
  logic                  act_lzs;

  logic [VW-1:0]         stg_val;
  logic [NUM_DIGITS-1:0] stg_dp;
  logic [NUM_DIGITS-1:0] stg_blank;
  logic                  stg_lzs;

  logic                  pend_q;
  logic [7:0]            led_q;
  logic [NUM_DIGITS-1:0] dig_q;
  logic                  fs_q;

  logic                  cnt_wrap;
  logic                  boundary;
  logic                  gap;

  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank_sel;
  logic                  sup_sel;
  logic [NUM_DIGITS-1:0] sup_vec;
  logic                  run;
  logic                  lit;
  logic [7:0]            led_d;
  logic [NUM_DIGITS-1:0] dig_d;
  logic                  fs_d;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign cnt_wrap = (cnt == CNT_MAX);
  assign boundary = cnt_wrap && (idx == IDX_MAX);

  generate
    if (BLANK_CYCLES == 0) begin : g_nogap
      assign gap = 1'b0;
    end else begin : g_gap
      assign gap = (cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A boundary load also refreshes staging so the next idle boundary
  // re-copies the same data instead of older staged contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_val   <= '0;
      act_dp    <= '0;
      act_blank <= '0;
      act_lzs   <= 1'b0;
      stg_val   <= '0;
      stg_dp    <= '0;
      stg_blank <= '0;
      stg_lzs   <= 1'b0;
      pend_q    <= 1'b0;
    end else if (boundary) begin
      pend_q <= 1'b0;
      if (bus.load) begin
        act_val   <= bus.value;
        act_dp    <= bus.dp;
        act_blank <= bus.blank;
        act_lzs   <= bus.lzs;
        stg_val   <= bus.value;
        stg_dp    <= bus.dp;
        stg_blank <= bus.blank;
        stg_lzs   <= bus.lzs;
      end else begin
        act_val   <= stg_val;
        act_dp    <= stg_dp;
        act_blank <= stg_blank;
        act_lzs   <= stg_lzs;
      end
    end else if (bus.load) begin
      stg_val   <= bus.value;
      stg_dp    <= bus.dp;
      stg_blank <= bus.blank;
      stg_lzs   <= bus.lzs;
      pend_q    <= 1'b1;
    end
  end

  // A digit is suppressed when it and every digit above it are zero.
  always_comb begin
    run     = 1'b1;
    sup_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run        = run & (act_val[4*i +: 4] == 4'h0);
      sup_vec[i] = run & act_lzs;
    end
  end

  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    sup_sel   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = act_val[4*i +: 4];
        dp_sel    = act_dp[i];
        blank_sel = act_blank[i];
        sup_sel   = sup_vec[i];
      end
    end
  end

  always_comb begin
    lit   = ~gap & ~blank_sel;
    led_d = 8'hFF;
    dig_d = '1;
    if (lit) begin
      led_d = {~dp_sel, sup_sel ? 7'h7F : enc(nib)};
      dig_d = ~(NUM_DIGITS'(1) << idx);
    end
    fs_d = (cnt == '0) && (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 8'hFF;
      dig_q <= '1;
      fs_q  <= 1'b0;
    end else begin
      led_q <= led_d;
      dig_q <= dig_d;
      fs_q  <= fs_d;
    end
  end

  assign bus.LED7S       = led_q;
  assign bus.dig         = dig_q;
  assign bus.frame_start = fs_q;
  assign bus.pending     = pend_q;

endmodule
